uart_cmd_sequencer: RTL and testbench

- Command sequencer between the receive FIFO, the register memory and the transmit FIFO of the UART.
- Pops command and data bytes from the receive FIFO and decodes them.
- Performs single or burst writes and reads of the memory.
- Pushes read data into the transmit FIFO, stalling on transmit-FIFO-full backpressure.

---
 rtl/uart_cmd_sequencer.sv | 110 +++++++++++
 tb/tb_uart_cmd_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_sequencer.sv
// uart_cmd_sequencer: decodes rx-FIFO command frames into memory burst writes/reads, streaming read data to the tx FIFO.
// Optional SCHED_ACK_EN adds an ACK state that pushes 8'hA5 after writes and 8'hEE on illegal opcodes.
module uart_cmd_sequencer #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_empty,
  input  logic [DW-1:0] rx_data,
  output logic          rx_rd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  input  logic          tx_full,
  output logic          tx_wr,
  output logic [DW-1:0] tx_data,
  output logic          busy,
  output logic          err
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GET_ADDR = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_REQ = 3'd3;
  localparam logic [2:0] S_RD_PUSH = 3'd4;
  localparam logic [AW-1:0] ONE = 1;
  logic [2:0] state;
  logic [3:0] cnt;
  logic [AW-1:0] addr;
  logic rd_op;
`ifdef SCHED_ACK_EN
  localparam logic [2:0] S_ACK = 3'd5;
  logic [DW-1:0] ack_byte;
  logic in_ack;
  assign in_ack = state == S_ACK;
`endif
  // every strobe is gated by rst so outputs read 0 during reset even mid-burst
  always_comb begin
    rx_rd = !rst && !rx_empty && (state == S_IDLE || state == S_GET_ADDR || state == S_WR_DATA);
    mem_we = rx_rd && state == S_WR_DATA;
    mem_wdata = mem_we ? rx_data : '0;
    mem_re = !rst && state == S_RD_REQ && !tx_full;
    mem_addr = rst ? '0 : addr;
    busy = !rst && state != S_IDLE;
`ifdef SCHED_ACK_EN
    tx_wr = !rst && (state == S_RD_PUSH || (in_ack && !tx_full));
    tx_data = !tx_wr ? '0 : in_ack ? ack_byte : mem_rdata;
`else
    tx_wr = !rst && state == S_RD_PUSH;
    tx_data = tx_wr ? mem_rdata : '0;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      addr <= '0;
      rd_op <= 1'b0;
      err <= 1'b0;
`ifdef SCHED_ACK_EN
      ack_byte <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (rx_rd) begin
          if (rx_data[7:6] == 2'b01 || rx_data[7:6] == 2'b10) begin
            cnt <= rx_data[3:0];
            rd_op <= rx_data[7];
            state <= S_GET_ADDR;
          end else if (rx_data[7:6] == 2'b11) begin
            err <= 1'b1;
`ifdef SCHED_ACK_EN
            ack_byte <= 8'hEE;
            state <= S_ACK;
`endif
          end
        end
        S_GET_ADDR: if (rx_rd) begin
          addr <= rx_data[AW-1:0];
          state <= rd_op ? S_RD_REQ : S_WR_DATA;
        end
        S_WR_DATA: if (rx_rd) begin
          addr <= addr + ONE;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) begin
`ifdef SCHED_ACK_EN
            ack_byte <= 8'hA5;
            state <= S_ACK;
`else
            state <= S_IDLE;
`endif
          end
        end
        S_RD_REQ: if (!tx_full) state <= S_RD_PUSH;
        // sole writer of the tx FIFO, so space seen in RD_REQ is still there now
        S_RD_PUSH: begin
          addr <= addr + ONE;
          cnt <= cnt - 4'd1;
          state <= cnt == 4'd0 ? S_IDLE : S_RD_REQ;
        end
`ifdef SCHED_ACK_EN
        S_ACK: if (!tx_full) state <= S_IDLE;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// tb_uart_cmd_sequencer: directed frames against a behavioural memory and tx log.
module tb_uart_cmd_sequencer;
  logic clk = 0, rst = 1, rx_empty = 1, tx_full = 0;
  logic [7:0] rx_data = 0, mem_rdata = 0, mem_wdata, tx_data;
  logic [3:0] mem_addr;
  logic rx_rd, mem_we, mem_re, tx_wr, busy, err;
  logic [7:0] mem [16];
  logic [7:0] wa[$], wd[$], ra[$], td[$];
  int wc[$];
  int cyc = 0, viol = 0, errors = 0, checks = 0;
  logic [31:0] outs;
  assign outs = {rx_rd, mem_we, mem_re, tx_wr, busy, mem_addr, mem_wdata, tx_data};

  always #5 clk = ~clk;

  uart_cmd_sequencer #(.AW(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data), .rx_rd(rx_rd),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .tx_full(tx_full), .tx_wr(tx_wr), .tx_data(tx_data),
    .busy(busy), .err(err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we && mem_re) viol++;
    if (tx_wr && tx_full) viol++;
    if (tx_wr) td.push_back(tx_data);
    if (mem_we) begin
      mem[mem_addr] = mem_wdata;
      wa.push_back({4'h0, mem_addr});
      wd.push_back(mem_wdata);
      wc.push_back(cyc);
    end
    if (mem_re) begin
      mem_rdata = mem[mem_addr];
      ra.push_back({4'h0, mem_addr});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    wa.delete(); wd.delete(); ra.delete(); td.delete(); wc.delete();
  endtask

  task automatic send(input logic [7:0] b);
    logic got = 0;
    rx_data = b;
    rx_empty = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      got = rx_rd;
    end
    chk("send_pop", {31'h0, got}, 32'h1);
    @(posedge clk);
    #1 rx_empty = 1;
  endtask

  task automatic wait_idle();
    logic idle = 0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      idle = !busy;
    end
    chk("idle_timeout", {31'h0, idle}, 32'h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    @(negedge clk);
    chk("rst_outs", outs, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_rst_outs", outs, 32'h0);
    @(posedge clk);
    #1;
    // single write then single read
    clear();
    send(8'h40); send(8'h03); send(8'h5A);
    wait_idle();
    chk("w1_cnt", wa.size(), 1);
    chk("w1_addr", wa[0], 8'h03);
    chk("w1_data", wd[0], 8'h5A);
`ifdef SCHED_ACK_EN
    chk("w1_ack_cnt", td.size(), 1);
    chk("w1_ack", td[0], 8'hA5);
`else
    chk("w1_no_tx", td.size(), 0);
`endif
    clear();
    send(8'h80); send(8'h03);
    wait_idle();
    chk("r1_re_cnt", ra.size(), 1);
    chk("r1_addr", ra[0], 8'h03);
    chk("r1_tx_cnt", td.size(), 1);
    chk("r1_data", td[0], 8'h5A);
    chk("r1_err", {31'h0, err}, 32'h0);
    // wrapping burst write
    clear();
    send(8'h43); send(8'h0E); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    wait_idle();
    chk("wrap_cnt", wa.size(), 4);
    chk("wrap_a0", wa[0], 8'h0E);
    chk("wrap_a1", wa[1], 8'h0F);
    chk("wrap_a2", wa[2], 8'h00);
    chk("wrap_a3", wa[3], 8'h01);
    chk("wrap_d3", wd[3], 8'h44);
    chk("wrap_back2back", wc[3] - wc[0], 3);
    // read with tx backpressure
    clear();
    tx_full = 1;
    send(8'h81); send(8'h00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_strobes", {30'h0, mem_re, tx_wr}, 32'h0);
      chk("stall_busy", {31'h0, busy}, 32'h1);
    end
    @(posedge clk);
    #1 tx_full = 0;
    wait_idle();
    chk("bp_re_cnt", ra.size(), 2);
    chk("bp_a0", ra[0], 8'h00);
    chk("bp_a1", ra[1], 8'h01);
    chk("bp_tx_cnt", td.size(), 2);
    chk("bp_d0", td[0], 8'h33);
    chk("bp_d1", td[1], 8'h44);
    // illegal opcode
    clear();
    send(8'hC0);
    @(negedge clk);
    chk("ill_err", {31'h0, err}, 32'h1);
`ifdef SCHED_ACK_EN
    wait_idle();
    chk("ill_tx_cnt", td.size(), 1);
    chk("ill_tx", td[0], 8'hEE);
`else
    chk("ill_idle", {31'h0, busy}, 32'h0);
    chk("ill_no_tx", td.size(), 0);
    @(posedge clk);
    #1;
`endif
    // receive starvation mid-write
    clear();
    send(8'h40); send(8'h07);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("gap_busy", {31'h0, busy}, 32'h1);
      chk("gap_strobes", {29'h0, mem_we, mem_re, tx_wr}, 32'h0);
    end
    @(posedge clk);
    #1;
    send(8'h77);
    wait_idle();
    chk("gap_cnt", wa.size(), 1);
    chk("gap_addr", wa[0], 8'h07);
    chk("gap_data", wd[0], 8'h77);
    chk("gap_err_sticky", {31'h0, err}, 32'h1);
    // reset mid-burst
    clear();
    send(8'h4F); send(8'h05); send(8'hAA); send(8'hBB);
    rx_data = 8'hCC;
    rx_empty = 0;
    rst = 1;
    @(negedge clk);
    chk("rst_mid_outs", outs, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    rx_empty = 1;
    @(negedge clk);
    chk("rst_done_outs", outs, 32'h0);
    chk("rst_done_err", {31'h0, err}, 32'h0);
    repeat (5) @(negedge clk);
    chk("rst_wr_cnt", wa.size(), 2);
    chk("rst_wr_a1", wa[1], 8'h06);
    chk("rst_mem5", mem[5], 8'hAA);
    chk("rst_mem6", mem[6], 8'hBB);
    chk("violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
